ppu_bg_shifter: RTL and testbench

Parametrised background pixel shifter for the PPU. It takes fetched tile rows (N bitplanes plus a palette attribute) over a valid/ready handshake into a one-entry staging buffer, then shifts them out one pixel per (scalex+1) clocks. It supports fine horizontal scroll, horizontal flip and underrun reporting. It sits between the background tile fetcher and the pixel mux/palette lookup, on the 25 MHz pixel clock.

---
 rtl/ppu_bg_shifter.sv | 216 +++++++++++++++++++++
 tb/tb_ppu_bg_shifter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ppu_bg_shifter.sv
// ppu_bg_shifter -- background pixel shifter for the PPU.
//
// Takes fetched tile rows (BPP bitplanes + palette attribute) through a
// valid/ready handshake into a one-entry staging buffer. It then shifts them
// out one pixel every (scalex+1) clocks, with fine horizontal scroll on the
// first tile of a line, optional horizontal flip, and underrun reporting.
//
// Optional feature macro: PPU_BGSHIFT_FLIP_EN
//   defined     -> tile_flip mirrors each plane when the tile is accepted
//   not defined -> tile_flip is ignored and tiles are stored unmodified
//
// Ports (all on the rising edge of clk_25mhz):
//   rst          synchronous active-high reset
//   enable       visible span of a scanline
//   scalex       pixel hold is scalex+1 clocks, sampled at pixel boundaries
//   fine_x       pixels of the first tile to skip, sampled on line start
//   tile_valid / tile_ready / tile_planes / tile_attr / tile_flip
//                tile handshake from the background fetcher
//   pixel_out    {attr, plane[BPP-1] bit .. plane[0] bit}, registered
//   pixel_valid  pixel_out holds a real pixel
//   underrun     one-cycle pulse per pixel period with no tile available

// One bitplane: staging row plus active shift register.
module ppu_bg_plane #(
  parameter int TILE_W = 8,
  parameter int XW     = 3
) (
  input  logic              clk_25mhz,
  input  logic              rst,
  input  logic              flush,
  input  logic              accept,
  input  logic [TILE_W-1:0] din,
  input  logic              load,
  input  logic [XW-1:0]     pre_shift,
  input  logic              shift,
  output logic              msb_nxt
);
  logic [TILE_W-1:0] stage_q, act_q, act_d;

  always_comb begin
    act_d = act_q;
    if (flush)      act_d = '0;
    else if (load)  act_d = stage_q << pre_shift;
    else if (shift) act_d = act_q << 1;
  end

  // The output register samples the next active state so that the first
  // pixel appears one cycle after the line-start cycle.
  assign msb_nxt = act_d[TILE_W-1];

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      stage_q <= '0;
      act_q   <= '0;
    end else begin
      act_q <= act_d;
      if (flush)       stage_q <= '0;
      else if (accept) stage_q <= din;
    end
  end
endmodule

module ppu_bg_shifter #(
  parameter  int BPP     = 2,
  parameter  int TILE_W  = 8,
  parameter  int SCALE_W = 2,
  parameter  int PAL_W   = 2,
  localparam int XW      = $clog2(TILE_W)
) (
  input  logic                  clk_25mhz,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [SCALE_W-1:0]    scalex,
  input  logic [XW-1:0]         fine_x,
  input  logic                  tile_valid,
  output logic                  tile_ready,
  input  logic [BPP*TILE_W-1:0] tile_planes,
  input  logic [PAL_W-1:0]      tile_attr,
  input  logic                  tile_flip,
  output logic [PAL_W+BPP-1:0]  pixel_out,
  output logic                  pixel_valid,
  output logic                  underrun
);
  localparam logic [XW:0] TILE_CNT = (XW+1)'(TILE_W);

  logic               en_d, line_start, running, flush, accept, boundary;
  logic               stage_full, act_loaded, act_loaded_d;
  logic [PAL_W-1:0]   stage_attr, act_attr, attr_d;
  logic [XW:0]        pix_cnt, pix_d;
  logic [SCALE_W-1:0] scale_cnt, scale_d;
  logic               do_load, do_shift, valid_d;
  logic [XW-1:0]      pre_shift;
  logic [BPP-1:0]     msb_nxt;

  assign line_start = enable & ~en_d;
  assign running    = enable & en_d;
  assign flush      = ~enable & en_d;
  assign tile_ready = ~stage_full & ~rst & ~flush;
  assign accept     = tile_valid & tile_ready;
  assign boundary   = line_start | (running & (scale_cnt == '0));

  for (genvar p = 0; p < BPP; p++) begin : g_plane
    logic [TILE_W-1:0] raw, din;
    assign raw = tile_planes[p*TILE_W +: TILE_W];
`ifdef PPU_BGSHIFT_FLIP_EN
    logic [TILE_W-1:0] rev;
    always_comb begin
      for (int i = 0; i < TILE_W; i++) rev[i] = raw[TILE_W-1-i];
    end
    assign din = tile_flip ? rev : raw;
`else
    assign din = raw;
`endif
    ppu_bg_plane #(.TILE_W(TILE_W), .XW(XW)) u_plane (
      .clk_25mhz (clk_25mhz),
      .rst       (rst),
      .flush     (flush),
      .accept    (accept),
      .din       (din),
      .load      (do_load),
      .pre_shift (pre_shift),
      .shift     (do_shift),
      .msb_nxt   (msb_nxt[p])
    );
  end

`ifndef PPU_BGSHIFT_FLIP_EN
  logic unused_flip;
  assign unused_flip = tile_flip;
`endif

  // Next-state for the active side. Staging never feeds active in the
  // cycle it is written, so a load always uses the registered stage_full.
  always_comb begin
    do_load      = 1'b0;
    do_shift     = 1'b0;
    pre_shift    = '0;
    act_loaded_d = act_loaded;
    attr_d       = act_attr;
    pix_d        = pix_cnt;
    scale_d      = scale_cnt;
    if (line_start) begin
      scale_d = scalex;
      if (stage_full) begin
        do_load      = 1'b1;
        pre_shift    = fine_x;
        act_loaded_d = 1'b1;
        attr_d       = stage_attr;
        pix_d        = TILE_CNT - {1'b0, fine_x};
      end else begin
        act_loaded_d = 1'b0;
        pix_d        = '0;
      end
    end else if (running) begin
      if (scale_cnt != '0) begin
        scale_d = scale_cnt - SCALE_W'(1);
      end else begin
        scale_d = scalex;
        if (act_loaded && pix_cnt != (XW+1)'(1)) begin
          do_shift = 1'b1;
          pix_d    = pix_cnt - (XW+1)'(1);
        end else if (stage_full) begin
          // Tile exhausted (or recovering from underrun): refill unshifted.
          do_load      = 1'b1;
          act_loaded_d = 1'b1;
          attr_d       = stage_attr;
          pix_d        = TILE_CNT;
        end else begin
          act_loaded_d = 1'b0;
          pix_d        = '0;
        end
      end
    end else begin
      // Blank (including the flush cycle): everything parks at zero.
      act_loaded_d = 1'b0;
      attr_d       = '0;
      pix_d        = '0;
      scale_d      = '0;
    end
  end

  assign valid_d = enable & act_loaded_d;

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      en_d        <= 1'b0;
      stage_full  <= 1'b0;
      stage_attr  <= '0;
      act_loaded  <= 1'b0;
      act_attr    <= '0;
      pix_cnt     <= '0;
      scale_cnt   <= '0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      en_d        <= enable;
      act_loaded  <= act_loaded_d;
      act_attr    <= attr_d;
      pix_cnt     <= pix_d;
      scale_cnt   <= scale_d;
      pixel_valid <= valid_d;
      pixel_out   <= valid_d ? {attr_d, msb_nxt} : '0;
      underrun    <= enable & boundary & ~act_loaded_d;
      if (flush) begin
        stage_full <= 1'b0;
        stage_attr <= '0;
      end else if (accept) begin
        stage_full <= 1'b1;
        stage_attr <= tile_attr;
      end else if (do_load) begin
        stage_full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ppu_bg_shifter.sv
// Self-checking bench for ppu_bg_shifter (default parameters).
// Expected pixel streams are derived from the latency rule: the pixel at
// offset k of a line appears at L+1+k*(scalex+1) and is held scalex+1 clocks.
module tb_ppu_bg_shifter;
  localparam int BPP = 2, TILE_W = 8, SCALE_W = 2, PAL_W = 2, XW = 3;
  localparam int PW = PAL_W + BPP;
  localparam int NB = BPP * TILE_W;

  logic               clk_25mhz = 1'b0;
  logic               rst = 1'b1, enable = 1'b0;
  logic [SCALE_W-1:0] scalex = '0;
  logic [XW-1:0]      fine_x = '0;
  logic               tile_valid = 1'b0, tile_ready, tile_flip = 1'b0;
  logic [NB-1:0]      tile_planes = '0;
  logic [PAL_W-1:0]   tile_attr = '0;
  logic [PW-1:0]      pixel_out;
  logic               pixel_valid, underrun;

  ppu_bg_shifter #(.BPP(BPP), .TILE_W(TILE_W), .SCALE_W(SCALE_W), .PAL_W(PAL_W)) dut (
    .clk_25mhz(clk_25mhz), .rst(rst), .enable(enable), .scalex(scalex), .fine_x(fine_x),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_planes(tile_planes),
    .tile_attr(tile_attr), .tile_flip(tile_flip), .pixel_out(pixel_out),
    .pixel_valid(pixel_valid), .underrun(underrun)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int cyc = 0;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  typedef struct { int c; logic [PW-1:0] pix; logic vld; logic ur; } exp_t;
  exp_t sb[$];

  task automatic push(input int c, input logic [PW-1:0] p, input logic v, input logic u);
    exp_t e;
    e.c = c; e.pix = p; e.vld = v; e.ur = u;
    sb.push_back(e);
  endtask

  always @(negedge clk_25mhz) begin
    while (sb.size() > 0 && sb[0].c < cyc) begin
      chk("sb_missed", 32'(sb[0].c), 32'(cyc));
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].c == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("pixel_out", 32'(pixel_out), 32'(e.pix));
      chk("pixel_valid", 32'(pixel_valid), 32'(e.vld));
      chk("underrun", 32'(underrun), 32'(e.ur));
    end
  end

  // Pixel idx (0 = leftmost) of a stored tile.
  function automatic logic [PW-1:0] pix_of(input logic [NB-1:0] pl, input logic [PAL_W-1:0] a, input int idx);
    logic [PW-1:0] r;
    r = {a, {BPP{1'b0}}};
    for (int p = 0; p < BPP; p++) r[p] = pl[p*TILE_W + TILE_W-1-idx];
    return r;
  endfunction

  function automatic logic [NB-1:0] stored(input logic [NB-1:0] pl, input logic flip);
    logic [NB-1:0] r;
    r = pl;
`ifdef PPU_BGSHIFT_FLIP_EN
    if (flip)
      for (int p = 0; p < BPP; p++)
        for (int i = 0; i < TILE_W; i++) r[p*TILE_W + i] = pl[p*TILE_W + TILE_W-1-i];
`endif
    return r;
  endfunction

  task automatic push_tile(input int start, input logic [NB-1:0] pl, input logic [PAL_W-1:0] a,
                           input int first, input int cnt, input int s, output int last);
    for (int k = 0; k < cnt; k++)
      for (int h = 0; h <= s; h++) push(start + k*(s+1) + h, pix_of(pl, a, first+k), 1'b1, 1'b0);
    last = start + cnt*(s+1) - 1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin @(posedge clk_25mhz); #1; end
  endtask

  task automatic send_tile(input logic [NB-1:0] pl, input logic [PAL_W-1:0] a, input logic f, output int acc);
    int n;
    n = 0; acc = -1;
    tile_valid = 1'b1; tile_planes = pl; tile_attr = a; tile_flip = f;
    while (acc < 0 && n < 60) begin
      @(negedge clk_25mhz);
      if (tile_ready) acc = cyc;
      @(posedge clk_25mhz); #1;
      n++;
    end
    tile_valid = 1'b0; tile_flip = 1'b0;
    if (acc < 0) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  // Line end after the active side has run dry at cycle last.
  task automatic end_line(input int last);
    push(last+1, '0, 1'b0, 1'b1);
    push(last+2, '0, 1'b0, 1'b0);
    goto(last+1);
    enable = 1'b0;
    @(negedge clk_25mhz); chk("flush_ready", 32'(tile_ready), 32'd0);
    @(posedge clk_25mhz); #1;
    @(negedge clk_25mhz); chk("post_flush_ready", 32'(tile_ready), 32'd1);
    @(posedge clk_25mhz); #1;
  endtask

  // Two-tile line: tile a prefetched in blank, tile b fetched during the line.
  task automatic run_line(input logic [NB-1:0] a, input logic [PAL_W-1:0] aa, input logic af,
                          input logic [NB-1:0] b, input logic [PAL_W-1:0] ba, input logic bf,
                          input int f, input int s);
    int acc, L, e0, e1;
    send_tile(a, aa, af, acc);
    scalex = SCALE_W'(s); fine_x = XW'(f);
    enable = 1'b1; L = cyc;
    push_tile(L+1, stored(a, af), aa, f, TILE_W-f, s, e0);
    push_tile(e0+1, stored(b, bf), ba, 0, TILE_W, s, e1);
    send_tile(b, ba, bf, acc);
    chk("refill_accept_cyc", 32'(acc), 32'(L+1));
    end_line(e1);
  endtask

  initial begin
    int acc, L, e;
    // Reset and idle.
    repeat (3) @(posedge clk_25mhz);
    #1;
    @(negedge clk_25mhz);
    chk("rst_pixel_out", 32'(pixel_out), 32'd0);
    chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_tile_ready", 32'(tile_ready), 32'd0);
    @(posedge clk_25mhz); #1;
    rst = 1'b0;
    @(negedge clk_25mhz);
    chk("ready_after_rst", 32'(tile_ready), 32'd1);
    @(posedge clk_25mhz); #1;

    // Basic line: plane0 = F0, plane1 = 0F, attr 2.
    run_line({8'h0F, 8'hF0}, 2'b10, 1'b0, {8'h53, 8'hCA}, 2'b01, 1'b0, 0, 0);
    // Scale and scroll.
    run_line({8'h00, 8'b1000_0100}, 2'b00, 1'b0, {8'hFF, 8'h5A}, 2'b11, 1'b0, 3, 2);
    // Maximum fine scroll with maximum scale.
    run_line({8'h3C, 8'h81}, 2'b01, 1'b0, {8'h96, 8'h0F}, 2'b10, 1'b0, 7, 3);

    // Flip, then underrun and recovery.
    send_tile({8'h80, 8'h01}, 2'b01, 1'b1, acc);
    scalex = '0; fine_x = '0;
    enable = 1'b1; L = cyc;
    push_tile(L+1, stored({8'h80, 8'h01}, 1'b1), 2'b01, 0, TILE_W, 0, e);
    for (int c = L+9; c <= L+12; c++) push(c, '0, 1'b0, 1'b1);
    goto(L+11);
    send_tile({8'h0C, 8'hE7}, 2'b11, 1'b0, acc);
    chk("underrun_accept_cyc", 32'(acc), 32'(L+11));
    push_tile(acc+2, {8'h0C, 8'hE7}, 2'b11, 0, TILE_W, 0, e);
    end_line(e);

    // Line end with staging full: stale tile must be discarded.
    send_tile({8'h12, 8'hB4}, 2'b10, 1'b0, acc);
    enable = 1'b1; L = cyc;
    push_tile(L+1, {8'h12, 8'hB4}, 2'b10, 0, 4, 0, e);
    push(L+5, '0, 1'b0, 1'b0);
    send_tile({8'hFF, 8'hFF}, 2'b11, 1'b0, acc);
    chk("stale_accept_cyc", 32'(acc), 32'(L+1));
    goto(L+4);
    enable = 1'b0;
    @(negedge clk_25mhz); chk("flush_full_ready", 32'(tile_ready), 32'd0);
    @(posedge clk_25mhz); #1;
    @(negedge clk_25mhz); chk("stale_gone_ready", 32'(tile_ready), 32'd1);
    @(posedge clk_25mhz); #1;

    // Fresh line, then reset mid-line.
    send_tile({8'h6D, 8'h2B}, 2'b01, 1'b0, acc);
    enable = 1'b1; L = cyc;
    push_tile(L+1, {8'h6D, 8'h2B}, 2'b01, 0, 3, 0, e);
    push(L+4, '0, 1'b0, 1'b0);
    goto(L+3);
    rst = 1'b1; enable = 1'b0;
    @(negedge clk_25mhz); chk("midline_rst_ready", 32'(tile_ready), 32'd0);
    @(posedge clk_25mhz); #1;
    rst = 1'b0;
    @(negedge clk_25mhz); chk("ready_after_midline_rst", 32'(tile_ready), 32'd1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk_25mhz);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
